// File: rtl/score_pkg.sv
// Shared encodings and helpers for the combo scoring engine.
// Optional feature macro used by the engine: SCORE_JUDGE_STATS_EN.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SONG_SELECT = 2'd1,
        ST_GAME_PLAY   = 2'd2,
        ST_GAME_OVER   = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        GR_MISS    = 2'd0,
        GR_GOOD    = 2'd1,
        GR_GREAT   = 2'd2,
        GR_PERFECT = 2'd3
    } grade_e;

    localparam int unsigned DEF_PTS_PERFECT = 10;
    localparam int unsigned DEF_PTS_GREAT   = 8;
    localparam int unsigned DEF_PTS_GOOD    = 5;

    // Multiplier from the current combo: 1 with no combo, then one tier step
    // every 2**tier_shift hits starting at 2, clamped to max_mult.
    function automatic logic [4:0] calc_mult(input logic [31:0]   combo,
                                             input int unsigned   tier_shift,
                                             input int unsigned   max_mult);
        logic [31:0] t;
        if (combo == 32'd0) begin
            t = 32'd1;
        end else begin
            t = ((combo - 32'd1) >> tier_shift) + 32'd2;
            if (t > 32'(max_mult)) begin
                t = 32'(max_mult);
            end
        end
        return t[4:0];
    endfunction

endpackage

// File: rtl/score_combo_engine_if.sv
// Judgement inputs and score outputs of the combo scoring engine.
// Optional feature macro: SCORE_JUDGE_STATS_EN adds per-grade counters.
interface score_combo_engine_if #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned SCORE_W = 20,
    parameter int unsigned COMBO_W = 8
);
    logic [1:0]         current_state;
    logic [LANES-1:0]   hit_valid;
    logic [2*LANES-1:0] hit_grade;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [4:0]         multiplier;
    logic               score_sat;
`ifdef SCORE_JUDGE_STATS_EN
    logic [COMBO_W-1:0] perfect_cnt;
    logic [COMBO_W-1:0] great_cnt;
    logic [COMBO_W-1:0] good_cnt;
    logic [COMBO_W-1:0] miss_cnt;

    modport master (
        output current_state, hit_valid, hit_grade,
        input  score, combo, max_combo, multiplier, score_sat,
        input  perfect_cnt, great_cnt, good_cnt, miss_cnt
    );
    modport slave (
        input  current_state, hit_valid, hit_grade,
        output score, combo, max_combo, multiplier, score_sat,
        output perfect_cnt, great_cnt, good_cnt, miss_cnt
    );
`else
    modport master (
        output current_state, hit_valid, hit_grade,
        input  score, combo, max_combo, multiplier, score_sat
    );
    modport slave (
        input  current_state, hit_valid, hit_grade,
        output score, combo, max_combo, multiplier, score_sat
    );
`endif
endinterface

// File: rtl/score_lane_sum.sv
// Stage-1 reduction over all lanes: base points, hit count, miss flag.
// Optional feature macro: SCORE_JUDGE_STATS_EN exposes per-grade lane counts.
module score_lane_sum
    import score_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int unsigned PTS_GREAT   = DEF_PTS_GREAT,
    parameter int unsigned PTS_GOOD    = DEF_PTS_GOOD,
    parameter int unsigned PTS_W       = 6,
    parameter int unsigned CNT_W       = 3
) (
    input  logic [LANES-1:0]   hit_valid_i,
    input  logic [2*LANES-1:0] hit_grade_i,
    output logic [PTS_W-1:0]   pts_sum_o,
    output logic [CNT_W-1:0]   hit_cnt_o,
    output logic               miss_o,
    output logic               any_vld_o
`ifdef SCORE_JUDGE_STATS_EN
    ,
    output logic [CNT_W-1:0]   perfect_cnt_o,
    output logic [CNT_W-1:0]   great_cnt_o,
    output logic [CNT_W-1:0]   good_cnt_o,
    output logic [CNT_W-1:0]   miss_cnt_o
`endif
);

    logic [CNT_W-1:0] n_perfect, n_great, n_good, n_miss;
    grade_e           g;

    // Per-grade lane counts and point total; grades on invalid lanes are ignored.
    always_comb begin
        pts_sum_o = '0;
        n_perfect = '0;
        n_great   = '0;
        n_good    = '0;
        n_miss    = '0;
        g         = GR_MISS;
        for (int unsigned i = 0; i < LANES; i++) begin
            g = grade_e'(hit_grade_i[2*i +: 2]);
            if (hit_valid_i[i]) begin
                case (g)
                    GR_PERFECT: begin
                        pts_sum_o = pts_sum_o + PTS_W'(PTS_PERFECT);
                        n_perfect = n_perfect + CNT_W'(1);
                    end
                    GR_GREAT: begin
                        pts_sum_o = pts_sum_o + PTS_W'(PTS_GREAT);
                        n_great   = n_great + CNT_W'(1);
                    end
                    GR_GOOD: begin
                        pts_sum_o = pts_sum_o + PTS_W'(PTS_GOOD);
                        n_good    = n_good + CNT_W'(1);
                    end
                    default: n_miss = n_miss + CNT_W'(1);
                endcase
            end
        end
    end

    assign hit_cnt_o = n_perfect + n_great + n_good;
    assign miss_o    = |n_miss;
    assign any_vld_o = |hit_valid_i;

`ifdef SCORE_JUDGE_STATS_EN
    assign perfect_cnt_o = n_perfect;
    assign great_cnt_o   = n_great;
    assign good_cnt_o    = n_good;
    assign miss_cnt_o    = n_miss;
`endif

endmodule

// File: rtl/score_combo_engine.sv
// Two-stage multi-lane scoring engine: stage 1 registers the lane reduction,
// stage 2 accumulates saturating score, combo and max combo.
// Optional feature macro: SCORE_JUDGE_STATS_EN adds per-grade judgement counters.
module score_combo_engine
    import score_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned SCORE_W     = 20,
    parameter int unsigned COMBO_W     = 8,
    parameter int unsigned TIER_SHIFT  = 4,
    parameter int unsigned MAX_MULT    = 17,
    parameter int unsigned PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int unsigned PTS_GREAT   = DEF_PTS_GREAT,
    parameter int unsigned PTS_GOOD    = DEF_PTS_GOOD
) (
    input  logic                 clk,
    input  logic                 rst,
    score_combo_engine_if.slave  bus
);

    localparam int unsigned PTS_W = $clog2(LANES * PTS_PERFECT + 1);
    localparam int unsigned CNT_W = $clog2(LANES + 1);
    localparam int unsigned AW    = SCORE_W + 6;

    game_state_e        state;
    logic [PTS_W-1:0]   pts_sum;
    logic [CNT_W-1:0]   hit_cnt;
    logic               miss, any_vld;

    logic               s1_vld_q, s1_vld_d;
    logic [PTS_W-1:0]   s1_pts_q, s1_pts_d;
    logic [CNT_W-1:0]   s1_hits_q, s1_hits_d;
    logic               s1_miss_q, s1_miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_q, max_d;
    logic               sat_q, sat_d;
    logic [4:0]         mult;
    logic [AW-1:0]      prod, ssum;

`ifdef SCORE_JUDGE_STATS_EN
    // Index by grade encoding: 0 miss, 1 good, 2 great, 3 perfect.
    logic [3:0][CNT_W-1:0]   gcnt;
    logic [3:0][CNT_W-1:0]   s1_gcnt_q, s1_gcnt_d;
    logic [3:0][COMBO_W-1:0] stat_q, stat_d;
`endif

    function automatic logic [COMBO_W-1:0] sat_add(input logic [COMBO_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [COMBO_W:0] s;
        s = {1'b0, a} + (COMBO_W+1)'(b);
        return s[COMBO_W] ? '1 : s[COMBO_W-1:0];
    endfunction

    assign state = game_state_e'(bus.current_state);

    score_lane_sum #(
        .LANES       (LANES),
        .PTS_PERFECT (PTS_PERFECT),
        .PTS_GREAT   (PTS_GREAT),
        .PTS_GOOD    (PTS_GOOD),
        .PTS_W       (PTS_W),
        .CNT_W       (CNT_W)
    ) u_lane_sum (
        .hit_valid_i   (bus.hit_valid),
        .hit_grade_i   (bus.hit_grade),
        .pts_sum_o     (pts_sum),
        .hit_cnt_o     (hit_cnt),
        .miss_o        (miss),
        .any_vld_o     (any_vld)
`ifdef SCORE_JUDGE_STATS_EN
        ,
        .perfect_cnt_o (gcnt[3]),
        .great_cnt_o   (gcnt[2]),
        .good_cnt_o    (gcnt[1]),
        .miss_cnt_o    (gcnt[0])
`endif
    );

    // Multiplier reflects the committed combo, so a commit uses the pre-update tier.
    assign mult = calc_mult(32'(combo_q), TIER_SHIFT, MAX_MULT);
    assign prod = AW'(s1_pts_q) * AW'(mult);
    assign ssum = AW'(score_q) + prod;

    // Next state: song select clears everything; otherwise commit stage 2, then refill stage 1.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_pts_d  = s1_pts_q;
        s1_hits_d = s1_hits_q;
        s1_miss_d = s1_miss_q;
        score_d   = score_q;
        combo_d   = combo_q;
        max_d     = max_q;
        sat_d     = sat_q;
`ifdef SCORE_JUDGE_STATS_EN
        s1_gcnt_d = s1_gcnt_q;
        stat_d    = stat_q;
`endif
        if (state == ST_SONG_SELECT) begin
            s1_vld_d = 1'b0;
            score_d  = '0;
            combo_d  = '0;
            max_d    = '0;
            sat_d    = 1'b0;
`ifdef SCORE_JUDGE_STATS_EN
            stat_d   = '0;
`endif
        end else begin
            if (s1_vld_q) begin
                if (|ssum[AW-1:SCORE_W]) begin
                    score_d = '1;
                    sat_d   = 1'b1;
                end else begin
                    score_d = ssum[SCORE_W-1:0];
                end
                combo_d = s1_miss_q ? '0 : sat_add(combo_q, s1_hits_q);
                if (combo_d > max_q) begin
                    max_d = combo_d;
                end
`ifdef SCORE_JUDGE_STATS_EN
                for (int unsigned k = 0; k < 4; k++) begin
                    stat_d[k] = sat_add(stat_q[k], s1_gcnt_q[k]);
                end
`endif
            end
            s1_vld_d = 1'b0;
            if (state == ST_GAME_PLAY) begin
                s1_vld_d  = any_vld;
                s1_pts_d  = pts_sum;
                s1_hits_d = hit_cnt;
                s1_miss_d = miss;
`ifdef SCORE_JUDGE_STATS_EN
                s1_gcnt_d = gcnt;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_pts_q  <= '0;
            s1_hits_q <= '0;
            s1_miss_q <= 1'b0;
            score_q   <= '0;
            combo_q   <= '0;
            max_q     <= '0;
            sat_q     <= 1'b0;
`ifdef SCORE_JUDGE_STATS_EN
            s1_gcnt_q <= '0;
            stat_q    <= '0;
`endif
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_pts_q  <= s1_pts_d;
            s1_hits_q <= s1_hits_d;
            s1_miss_q <= s1_miss_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            max_q     <= max_d;
            sat_q     <= sat_d;
`ifdef SCORE_JUDGE_STATS_EN
            s1_gcnt_q <= s1_gcnt_d;
            stat_q    <= stat_d;
`endif
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_q;
    assign bus.multiplier = mult;
    assign bus.score_sat  = sat_q;
`ifdef SCORE_JUDGE_STATS_EN
    assign bus.perfect_cnt = stat_q[3];
    assign bus.great_cnt   = stat_q[2];
    assign bus.good_cnt    = stat_q[1];
    assign bus.miss_cnt    = stat_q[0];
`endif

endmodule

// File: tb/tb_score_combo_engine.sv
// Bench for score_combo_engine: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_score_combo_engine;

    localparam longint SMAX = 64'd1048575;
    localparam longint CMAX = 64'd255;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    score_combo_engine_if #(.LANES(4), .SCORE_W(20), .COMBO_W(8)) bus ();

    score_combo_engine #(
        .LANES      (4),
        .SCORE_W    (20),
        .COMBO_W    (8),
        .TIER_SHIFT (4),
        .MAX_MULT   (17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    longint m_score, m_combo, m_max, m_sat;
    longint m_stat [4];
    bit     p_vld;
    longint p_pts, p_hits;
    bit     p_miss;
    longint p_g [4];
    longint m_sum;
    int     m_gr;

    initial begin
        m_score = 0; m_combo = 0; m_max = 0; m_sat = 0; p_vld = 0;
        p_pts = 0; p_hits = 0; p_miss = 0;
        for (int k = 0; k < 4; k++) begin m_stat[k] = 0; p_g[k] = 0; end
    end

    function automatic longint mdl_mult(input longint c);
        longint t;
        if (c == 0) return 1;
        t = (c + 15) / 16 + 1;
        return (t > 17) ? 17 : t;
    endfunction

    function automatic longint pts_of(input int g);
        case (g)
            3: return 10;
            2: return 8;
            1: return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_score = 0; m_combo = 0; m_max = 0; m_sat = 0; p_vld = 0;
            for (int k = 0; k < 4; k++) m_stat[k] = 0;
        end else if (bus.current_state == 2'd1) begin
            m_score = 0; m_combo = 0; m_max = 0; m_sat = 0; p_vld = 0;
            for (int k = 0; k < 4; k++) m_stat[k] = 0;
        end else begin
            if (p_vld) begin
                m_sum = m_score + p_pts * mdl_mult(m_combo);
                if (m_sum > SMAX) begin m_score = SMAX; m_sat = 1; end
                else m_score = m_sum;
                m_combo = p_miss ? 0 : ((m_combo + p_hits > CMAX) ? CMAX : m_combo + p_hits);
                if (m_combo > m_max) m_max = m_combo;
                for (int k = 0; k < 4; k++)
                    m_stat[k] = (m_stat[k] + p_g[k] > CMAX) ? CMAX : m_stat[k] + p_g[k];
            end
            p_vld = 0;
            if (bus.current_state == 2'd2 && bus.hit_valid != 4'd0) begin
                p_vld = 1; p_pts = 0;
                for (int k = 0; k < 4; k++) p_g[k] = 0;
                for (int i = 0; i < 4; i++) begin
                    if (bus.hit_valid[i]) begin
                        m_gr = int'((bus.hit_grade >> (2 * i)) & 8'd3);
                        p_pts += pts_of(m_gr);
                        p_g[m_gr] += 1;
                    end
                end
                p_hits = p_g[1] + p_g[2] + p_g[3];
                p_miss = (p_g[0] != 0);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_score", longint'(bus.score), m_score);
            chk("mdl_combo", longint'(bus.combo), m_combo);
            chk("mdl_max_combo", longint'(bus.max_combo), m_max);
            chk("mdl_multiplier", longint'(bus.multiplier), mdl_mult(m_combo));
            chk("mdl_score_sat", longint'(bus.score_sat), m_sat);
`ifdef SCORE_JUDGE_STATS_EN
            chk("mdl_perfect_cnt", longint'(bus.perfect_cnt), m_stat[3]);
            chk("mdl_great_cnt", longint'(bus.great_cnt), m_stat[2]);
            chk("mdl_good_cnt", longint'(bus.good_cnt), m_stat[1]);
            chk("mdl_miss_cnt", longint'(bus.miss_cnt), m_stat[0]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] st, input logic [3:0] v, input logic [7:0] g);
        @(negedge clk);
        bus.current_state = st;
        bus.hit_valid     = v;
        bus.hit_grade     = g;
    endtask

    task automatic settle();
        step(2'd2, 4'h0, 8'h00);
        step(2'd2, 4'h0, 8'h00);
    endtask

    task automatic lit(input string nm, input longint s, input longint c, input longint mx,
                       input longint mu, input longint sat);
        chk({nm, "_score"}, longint'(bus.score), s);
        chk({nm, "_combo"}, longint'(bus.combo), c);
        chk({nm, "_max"}, longint'(bus.max_combo), mx);
        chk({nm, "_mult"}, longint'(bus.multiplier), mu);
        chk({nm, "_sat"}, longint'(bus.score_sat), sat);
    endtask

    initial begin
        rst = 1'b0;
        bus.current_state = 2'd0;
        bus.hit_valid     = '0;
        bus.hit_grade     = '0;
        step(2'd0, 4'h0, 8'h00);
        step(2'd0, 4'h0, 8'h00);
        lit("reset", 0, 0, 0, 1, 0);
        chk_en = 1'b1;
        rst = 1'b1;

        // Tier progression with single-lane PERFECTs.
        step(2'd1, 4'h0, 8'h00);
        step(2'd2, 4'h1, 8'h03);
        settle();
        lit("first_hit", 10, 1, 1, 2, 0);
        step(2'd2, 4'h1, 8'h03);
        settle();
        lit("second_hit", 30, 2, 2, 2, 0);
        for (int i = 0; i < 14; i++) step(2'd2, 4'h1, 8'h03);
        settle();
        lit("combo16", 310, 16, 16, 2, 0);
        step(2'd2, 4'h1, 8'h03);
        settle();
        lit("combo17", 330, 17, 17, 3, 0);

        // Hit and miss in the same cycle.
        step(2'd1, 4'h0, 8'h00);
        for (int i = 0; i < 5; i++) step(2'd2, 4'h1, 8'h03);
        settle();
        lit("combo5", 90, 5, 5, 2, 0);
        step(2'd2, 4'h3, 8'h02);
        settle();
        lit("hit_miss", 106, 0, 5, 1, 0);

        // One lane of each grade.
        step(2'd1, 4'h0, 8'h00);
        step(2'd2, 4'hF, 8'hE4);
        settle();
        lit("grade_mix", 23, 0, 0, 1, 0);
`ifdef SCORE_JUDGE_STATS_EN
        chk("stats_perfect", longint'(bus.perfect_cnt), 1);
        chk("stats_great", longint'(bus.great_cnt), 1);
        chk("stats_good", longint'(bus.good_cnt), 1);
        chk("stats_miss", longint'(bus.miss_cnt), 1);
`endif

        // Last hit before GAME_OVER counts; GAME_OVER hits ignored; SONG_SELECT drops in-flight.
        step(2'd1, 4'h0, 8'h00);
        step(2'd2, 4'h1, 8'h03);
        step(2'd3, 4'h1, 8'h03);
        step(2'd3, 4'h1, 8'h03);
        step(2'd3, 4'h0, 8'h00);
        lit("game_over", 10, 1, 1, 2, 0);
        step(2'd2, 4'h1, 8'h03);
        step(2'd1, 4'h0, 8'h00);
        step(2'd0, 4'h0, 8'h00);
        lit("song_sel_flush", 0, 0, 0, 1, 0);
        step(2'd0, 4'h0, 8'h00);
        lit("song_sel_hold", 0, 0, 0, 1, 0);

        // Combo saturation then score saturation.
        step(2'd1, 4'h0, 8'h00);
        for (int i = 0; i < 63; i++) step(2'd2, 4'hF, 8'hFF);
        step(2'd2, 4'h3, 8'h0F);
        settle();
        chk("combo254", longint'(bus.combo), 254);
        step(2'd2, 4'hF, 8'hFF);
        settle();
        chk("combo255", longint'(bus.combo), 255);
        chk("combo255_mult", longint'(bus.multiplier), 17);
        step(2'd2, 4'hF, 8'hFF);
        settle();
        chk("combo_nowrap", longint'(bus.combo), 255);
        for (int i = 0; i < 1600; i++) step(2'd2, 4'hF, 8'hFF);
        settle();
        chk("score_max", longint'(bus.score), SMAX);
        chk("score_sat", longint'(bus.score_sat), 1);
        for (int i = 0; i < 3; i++) step(2'd3, 4'hF, 8'hFF);
        chk("sat_sticky_go", longint'(bus.score_sat), 1);
        step(2'd2, 4'h1, 8'h00);
        settle();
        lit("sat_after_miss", SMAX, 0, 255, 1, 1);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] st;
            r = int'($urandom_range(0, 99));
            st = (r < 75) ? 2'd2 : (r < 80) ? 2'd1 : (r < 90) ? 2'd3 : 2'd0;
            rst = ($urandom_range(0, 199) != 0);
            step(st, 4'($urandom), 8'($urandom));
        end
        rst = 1'b1;
        step(2'd0, 4'h0, 8'h00);
        step(2'd0, 4'h0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
